// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational winner search over a request vector.
// Round-robin from ptr+1 by default; lowest index wins when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  int unsigned cand;
  logic        found;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      cand = k;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
`else
    // Offsets start at 1 so the last winner is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
`endif
    any = found;
    win = found ? (N'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port among NUM_REQ requesters.
// Optional macro RAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             ram_cs,
  output logic                             ram_we,
  output logic                             ram_oe,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  output logic                             ram_wdata_en,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t            state, state_d;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    pick_req, pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any, grant;
  logic                  pick_we;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;

  assign pick_we    = req_we[pick_idx];
  assign pick_addr  = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_wdata = req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick_req = req;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (pick_req),
    .win     (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );
`else
  logic [IDX_W-1:0] ptr;

  // The current winner still holds req on the re-arbitration edge, so mask it out.
  always_comb begin
    pick_req = req;
    if (state != IDLE) pick_req = req & ~(NUM_REQ'(1) << win_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= IDX_W'(NUM_REQ - 1);
    else if (grant) ptr <= pick_idx;
  end

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (pick_req),
    .ptr     (ptr),
    .win     (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );
`endif

  // ram_we doubles as the latched direction of the access in flight.
  always_comb begin
    state_d = state;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!ram_we) begin
          state_d = RDCAP;
        end else if (pick_any) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      RDCAP: begin
        if (pick_any) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      win_idx      <= '0;
      gnt          <= '0;
      rd_valid     <= '0;
      rd_data      <= '0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_oe       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_wdata_en <= 1'b0;
    end else begin
      state    <= state_d;
      gnt      <= '0;
      rd_valid <= '0;
      if (state == RDCAP) begin
        rd_valid <= NUM_REQ'(1) << win_idx;
        rd_data  <= ram_rdata;
      end
      // RAM pins are registered from the state being entered.
      if (grant) begin
        win_idx      <= pick_idx;
        gnt          <= pick_oh;
        ram_cs       <= 1'b1;
        ram_we       <= pick_we;
        ram_oe       <= ~pick_we;
        ram_wdata_en <= pick_we;
        ram_addr     <= pick_addr;
        ram_wdata    <= pick_wdata;
      end else if (state_d == RDCAP) begin
        ram_cs       <= 1'b1;
        ram_we       <= 1'b0;
        ram_oe       <= 1'b1;
        ram_wdata_en <= 1'b0;
      end else begin
        ram_cs       <= 1'b0;
        ram_we       <= 1'b0;
        ram_oe       <= 1'b0;
        ram_wdata_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model with a small behavioural RAM on port 0.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 16;
  localparam int DW      = 8;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NUM_REQ-1:0]    req   = '0;
  logic [NUM_REQ-1:0]    req_we = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    gnt, rd_valid;
  logic [DW-1:0]         rd_data;
  logic                  ram_cs, ram_we, ram_oe, ram_wdata_en;
  logic [AW-1:0]         ram_addr;
  logic [DW-1:0]         ram_wdata;
  logic [DW-1:0]         ram_rdata;
  logic [DW-1:0]         ram_mem [16];

  int errors = 0, checks = 0, cyc = 0;
  int free_edge = 0, m_ptr = NUM_REQ - 1, last_win = 0, granted_now = -1, renew_mode = 0;
  bit chained = 1'b0, rand_on = 1'b0;
  logic [DW-1:0]      m_mem [16];
  logic [NUM_REQ-1:0] exp_gnt [int];
  logic [NUM_REQ-1:0] exp_rdv [int];
  logic [DW-1:0]      exp_rdd [int];
  logic [DW-1:0]      exp_wd  [int];
  logic [AW-1:0]      exp_addr [int];
  bit                 exp_cs  [int];
  bit                 exp_wen [int];
  int                 rel_at  [int];
  int                 obs_log [$];
  int                 obs_cyc [$];

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wdata_en(ram_wdata_en), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM view; cleared on reset so reads are predictable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_cs) begin
      if (ram_we)      ram_mem[ram_addr[3:0]] <= ram_wdata;
      else if (ram_oe) ram_rdata <= ram_mem[ram_addr[3:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int i, input int we, input int addr, input int data);
    req[i]                  = 1'b1;
    req_we[i]               = (we != 0);
    req_addr[i*AW +: AW]    = AW'(addr);
    req_wdata[i*DW +: DW]   = DW'(data);
  endtask

  // Arbitration at one edge: who may compete, who wins, and what each later cycle must show.
  task automatic modelEdge();
    logic [NUM_REQ-1:0] elig;
    int w, a;
    granted_now = -1;
    if (cyc < free_edge) return;
    elig = req;
`ifndef RAM_ARB_FIXED_PRIO_EN
    if (chained && cyc == free_edge) elig[last_win] = 1'b0;
`endif
    chained = 1'b0;
    if (elig == '0) return;
    w = -1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) if (w < 0 && elig[k]) w = k;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (w < 0 && elig[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
    m_ptr = w;
`endif
    last_win    = w;
    granted_now = w;
    chained     = 1'b1;
    a           = int'(req_addr[w*AW +: 4]);
    exp_gnt[cyc]  = NUM_REQ'(1) << w;
    exp_cs[cyc]   = 1'b1;
    exp_addr[cyc] = req_addr[w*AW +: AW];
    exp_wen[cyc]  = req_we[w];
    rel_at[cyc+1] = w;
    if (req_we[w]) begin
      exp_wd[cyc] = req_wdata[w*DW +: DW];
      m_mem[a]    = req_wdata[w*DW +: DW];
      free_edge   = cyc + 1;
    end else begin
      exp_cs[cyc+1]   = 1'b1;
      exp_addr[cyc+1] = req_addr[w*AW +: AW];
      exp_wen[cyc+1]  = 1'b0;
      exp_rdv[cyc+2]  = NUM_REQ'(1) << w;
      exp_rdd[cyc+2]  = m_mem[a];
      free_edge       = cyc + 2;
    end
  endtask

  task automatic releaseAgent(input int i);
    case (renew_mode)
      0: req[i] = 1'b0;
      1: ;
      default: begin
        if ($urandom_range(1) == 0) req[i] = 1'b0;
        else applyStimulus(i, $urandom_range(1), $urandom_range(15), $urandom_range(255));
      end
    endcase
  endtask

  task automatic randomTraffic();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req[i]) begin
        if ($urandom_range(2) == 0) applyStimulus(i, $urandom_range(1), $urandom_range(15), $urandom_range(255));
      end else if (i != granted_now && $urandom_range(19) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic checkCycle();
    bit cs_exp;
    checkOutput("gnt", gnt, exp_gnt.exists(cyc) ? exp_gnt[cyc] : '0);
    checkOutput("rd_valid", rd_valid, exp_rdv.exists(cyc) ? exp_rdv[cyc] : '0);
    if (exp_rdd.exists(cyc)) checkOutput("rd_data", rd_data, exp_rdd[cyc]);
    cs_exp = exp_cs.exists(cyc);
    checkOutput("ram_cs", ram_cs, cs_exp);
    checkOutput("ram_wdata_en", ram_wdata_en, exp_wen.exists(cyc) ? exp_wen[cyc] : 1'b0);
    if (cs_exp) begin
      checkOutput("ram_addr", ram_addr, exp_addr[cyc]);
      checkOutput("ram_we", ram_we, exp_wen[cyc]);
      checkOutput("ram_oe", ram_oe, !exp_wen[cyc]);
    end
    if (exp_wd.exists(cyc)) checkOutput("ram_wdata", ram_wdata, exp_wd[cyc]);
    if (gnt != '0) begin
      for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) obs_log.push_back(k);
      obs_cyc.push_back(cyc);
    end
    exp_gnt.delete(cyc); exp_rdv.delete(cyc); exp_rdd.delete(cyc);
    exp_cs.delete(cyc); exp_wen.delete(cyc); exp_addr.delete(cyc); exp_wd.delete(cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    if (rel_at.exists(cyc)) begin
      releaseAgent(rel_at[cyc]);
      rel_at.delete(cyc);
    end
    if (rand_on) randomTraffic();
    @(negedge clk);
    checkCycle();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_ram_cs", ram_cs, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_oe", ram_oe, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_wdata", ram_wdata, 0);
    checkOutput("rst_ram_wdata_en", ram_wdata_en, 0);
    req = '0;
    m_ptr = NUM_REQ - 1; free_edge = 0; chained = 1'b0; granted_now = -1;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    exp_gnt.delete(); exp_rdv.delete(); exp_rdd.delete(); exp_cs.delete();
    exp_wen.delete(); exp_addr.delete(); exp_wd.delete(); rel_at.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    #2;
    applyReset();

    $display("[TB] idle window");
    repeat (10) tick();

    $display("[TB] single write then read");
    applyStimulus(0, 1, 5, 8'hA5);
    repeat (3) tick();
    applyStimulus(0, 0, 5, 0);
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      tick();
      if (rd_valid[0]) lat = n;
    end
    checkOutput("rd_latency", lat, 3);
    checkOutput("rd_data_a5", rd_data, 8'hA5);
    repeat (2) tick();

    $display("[TB] four simultaneous writes");
    applyReset();
    obs_log.delete(); obs_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1, i, 8'h30 + i);
    repeat (6) tick();
    checkOutput("wr4_count", obs_log.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("wr4_order", obs_log.size() > i ? obs_log[i] : -1, i);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 0, i, 0);
    repeat (12) tick();

    $display("[TB] fairness with continuous reads");
    obs_log.delete(); obs_cyc.delete();
    renew_mode = 1;
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 2, 0);
    repeat (12) tick();
    renew_mode = 0;
    req = '0;
    repeat (4) tick();
    checkOutput("fair_count", obs_log.size(), 6);
    checkOutput("fair_first", obs_log.size() > 0 ? obs_log[0] : -1, 0);
    for (int i = 1; i < obs_log.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      checkOutput("fair_fixed", obs_log[i], 0);
`else
      checkOutput("fair_alt", obs_log[i], 1 - obs_log[i-1]);
`endif
    end

    $display("[TB] mixed read and write");
    applyReset();
    obs_log.delete(); obs_cyc.delete();
    applyStimulus(2, 0, 7, 0);
    applyStimulus(3, 1, 9, 8'h5C);
    repeat (6) tick();
    checkOutput("mix_first", obs_log.size() > 0 ? obs_log[0] : -1, 2);
    checkOutput("mix_second", obs_log.size() > 1 ? obs_log[1] : -1, 3);
    checkOutput("mix_gap", obs_cyc.size() > 1 ? obs_cyc[1] - obs_cyc[0] : -1, 2);

    $display("[TB] reset during read capture");
    applyStimulus(0, 0, 9, 0);
    repeat (2) tick();
    applyReset();
    obs_log.delete(); obs_cyc.delete();
    applyStimulus(1, 1, 4, 8'h11);
    applyStimulus(0, 1, 3, 8'h22);
    repeat (4) tick();
    checkOutput("post_rst_first", obs_log.size() > 0 ? obs_log[0] : -1, 0);

    $display("[TB] random traffic");
    renew_mode = 2;
    rand_on = 1'b1;
    repeat (400) tick();
    rand_on = 1'b0;
    renew_mode = 0;
    req = '0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the dual-port synchronous RAM (`ram_dp_sr_sw`) among `NUM_REQ` requesters. It sequences each granted access onto the RAM control pins (cs/we/oe/address/data) and returns read data to the winning requester with a valid pulse. It sits between the processing masters and RAM port 0; port 1 stays directly owned by its single client.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 16: RAM address width.
- `DATA_WIDTH`, 8: RAM data width.

Clock and reset (already decided): one clock, `clk`; reset `rst_n`, asynchronous, active-low.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester access request; held until granted.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice i.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data.
- `gnt`  out  NUM_REQ  one-hot grant, one cycle, during ACCESS.
- `rd_valid`  out  NUM_REQ  one-hot read-data-valid pulse.
- `rd_data`  out  DATA_WIDTH  registered read data; shared, qualified by `rd_valid`.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  RAM port controls.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_wdata`  out  DATA_WIDTH  write data for the RAM inout bus.
- `ram_wdata_en`  out  1  tristate enable for `ram_wdata`; equals `ram_cs & ram_we`.
- `ram_rdata`  in  DATA_WIDTH  RAM inout bus sampled value.

## Operation
- FSM states: IDLE, ACCESS, RDCAP.
- IDLE: if any `req`, select winner, latch its index, we, addr, wdata; go to ACCESS.
- ACCESS: `ram_cs`=1, `ram_addr`/`ram_we` from latched request; write: `ram_oe`=0, `ram_wdata_en`=1; read: `ram_oe`=1. `gnt[winner]`=1.
  - Write: if any `req` other than the winner is pending, re-arbitrate directly into ACCESS; else IDLE.
  - Read: go to RDCAP.
- RDCAP: hold `ram_cs`=1, `ram_oe`=1, `ram_we`=0, same address; capture `ram_rdata` into `rd_data` at cycle end; pulse `rd_valid[winner]` the next cycle. Then re-arbitrate into ACCESS or go to IDLE.
- Round-robin: pointer holds last winner; search starts at pointer+1 modulo NUM_REQ; pointer updates on every grant.
- The granted requester must drop `req`, or present a new request, in the cycle after `gnt`; the winner is excluded from the immediate re-arbitration out of ACCESS/RDCAP.
- A `req` withdrawn before grant produces no access.
- Reset, also mid-access: state IDLE, pointer = NUM_REQ-1 so requester 0 wins first. All outputs 0: `gnt`, `rd_valid`, `rd_data`, `ram_*`. Any in-flight read is dropped with no `rd_valid`.

## Timing
- `req` sampled at edge k (IDLE); ACCESS spans k..k+1 with `gnt` and RAM controls registered.
- Write commits at edge k+1.
- Read: RAM registers data at k+1; RDCAP spans k+1..k+2; `rd_data` and `rd_valid` are visible k+2..k+3. Read latency is 3 cycles from request sample to `rd_valid`.
- Throughput: back-to-back writes 1 access/cycle; reads 1 per 2 cycles.
- All outputs are registered; no combinational path from `req` to any output.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; lowest index wins, the pointer is not implemented, and the winner-exclusion rule is dropped.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `ram_arb_pkg`: state encoding constants (IDLE=2'd0, ACCESS=2'd1, RDCAP=2'd2) and the default width constants.
- One sub-module, `rr_pick`: combinational winner search, taking a request vector and pointer and producing a one-hot winner plus its index. Its fixed-priority variant is selected by the macro.

## Test plan
- Single write then read: req0 write addr 5 data 8'hA5, then read addr 5. Expect `gnt[0]` one cycle, then `rd_valid[0]` with `rd_data`=8'hA5 exactly 3 cycles after the read request is sampled.
- All four request writes simultaneously, held until granted: grants occur in order 0,1,2,3 on consecutive cycles, and RAM addresses 0..3 hold the respective data.
- Fairness: req0 and req1 reading continuously produce alternating grants 0,1,0,1. With `RAM_ARB_FIXED_PRIO_EN` defined, only req0 is granted.
- Mixed traffic: req2 read and req3 write pending together. Expect req2 ACCESS then RDCAP, then req3 ACCESS, with no RAM activity overlap and `ram_wdata_en` high only in req3's ACCESS.
- Reset asserted during RDCAP: all outputs drop to 0 immediately, with no `rd_valid`. After release, req0 wins first.
- Idle: no `req` for 10 cycles, so `ram_cs` stays 0 and `gnt` stays 0.
